// File: rtl/prim_sram_responder.sv
// -----------------------------------------------------------------------------
// prim_sram_responder
//
// Bridges a 16-bit CPU bus onto an 8-bit asynchronous byte SRAM. A request
// (byte or word, read or write) is captured in IDLE. The block then runs one
// SRAM access for a byte request, or two for a word request. Each access lasts
// WAIT+1 cycles. When the access sequence is done, the block pulses o_ack for
// one cycle.
//
// Words are little-endian. The low byte is at addr and the high byte is at
// addr+1, and the high-byte address wraps from 0xFFFF to 0x0000.
//
// Parameters
//   WAIT         SRAM cycles per byte strobe minus one (legal 1..15)
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_reset      synchronous active-high reset
//   i_addr       CPU byte address (unaligned words allowed)
//   i_dat        CPU write data
//   o_dat        CPU read data, held until the next read capture
//   i_bs         byte select: 01 byte, 11 word, 00/10 no request
//   i_we         1 = write, 0 = read
//   o_ack        one-cycle completion pulse
//   o_sram_addr  SRAM byte address
//   o_sram_dat   SRAM write data
//   i_sram_dat   SRAM read data (asynchronous, valid within WAIT cycles)
//   o_sram_we    SRAM write strobe, active-high
// -----------------------------------------------------------------------------
module prim_sram_responder #(
    parameter int unsigned WAIT = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_dat,
    output logic [15:0] o_dat,
    input  logic [1:0]  i_bs,
    input  logic        i_we,
    output logic        o_ack,
    output logic [15:0] o_sram_addr,
    output logic [7:0]  o_sram_dat,
    input  logic [7:0]  i_sram_dat,
    output logic        o_sram_we
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    localparam logic [3:0] WAIT_L = 4'(WAIT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        word_q, word_d;
    logic [15:0] sram_addr_q, sram_addr_d;
    logic [7:0]  sram_dat_q, sram_dat_d;
    logic [15:0] rdata_q, rdata_d;

    logic req;
    logic cnt_zero;

    // Only 01 and 11 are real requests; 10 is deliberately treated as idle.
    assign req      = (i_bs == 2'b01) || (i_bs == 2'b11);
    assign cnt_zero = (cnt_q == 4'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        word_d      = word_q;
        sram_addr_d = sram_addr_q;
        sram_dat_d  = sram_dat_q;
        rdata_d     = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // Latch the whole request so that the CPU may change its
                    // inputs freely until the ack. The low-byte address and
                    // data are presented from the first LO cycle.
                    state_d     = ST_LO;
                    cnt_d       = WAIT_L;
                    addr_d      = i_addr;
                    wdata_d     = i_dat;
                    we_d        = i_we;
                    word_d      = (i_bs == 2'b11);
                    sram_addr_d = i_addr;
                    sram_dat_d  = i_dat[7:0];
                end
            end

            ST_LO: begin
                if (cnt_zero) begin
                    if (!we_q) begin
                        rdata_d[7:0] = i_sram_dat;
                        if (!word_q) begin
                            rdata_d[15:8] = 8'h00;
                        end
                    end
                    if (word_q) begin
                        state_d     = ST_HI;
                        cnt_d       = WAIT_L;
                        sram_addr_d = addr_q + 16'd1;   // wraps 0xFFFF -> 0x0000
                        sram_dat_d  = wdata_q[15:8];
                    end else begin
                        state_d = ST_ACK;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_HI: begin
                if (cnt_zero) begin
                    if (!we_q) begin
                        rdata_d[15:8] = i_sram_dat;
                    end
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_ACK: begin
                // Always return to IDLE, so that a request held by the CPU
                // gets at least one IDLE cycle before it is accepted again.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            we_q        <= 1'b0;
            word_q      <= 1'b0;
            sram_addr_q <= 16'h0000;
            sram_dat_q  <= 8'h00;
            rdata_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            word_q      <= word_d;
            sram_addr_q <= sram_addr_d;
            sram_dat_q  <= sram_dat_d;
            rdata_q     <= rdata_d;
        end
    end

    // The strobe falls in the cnt==0 cycle. This gives the SRAM a hold cycle
    // in which the address and data are still stable after the write ends.
    assign o_sram_we   = we_q && ((state_q == ST_LO) || (state_q == ST_HI)) && !cnt_zero;
    assign o_ack       = (state_q == ST_ACK);
    assign o_dat       = rdata_q;
    assign o_sram_addr = sram_addr_q;
    assign o_sram_dat  = sram_dat_q;

endmodule
